mac_row_acc: RTL

- Downstream consumer of the LSTM weight-address generator: takes the weight word read at each generated address, plus the matching input/delta element, and accumulates a signed fixed-point dot product per row.
- One result per row of LEN elements; ROWS rows per pass, then done.
- The row result is shifted back to Q-format, saturated, and emitted with a single-cycle valid pulse to the gate/error-update stage.

---
 rtl/mac_row_acc_if.sv | 45 ++++
 rtl/mac_row_acc.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mac_row_acc_if.sv
// mac_row_acc_if: bundles the data/control signals of mac_row_acc.
//
// Handshake (valid-only, no back-pressure):
//   - An i_w/i_x pair is consumed on a rising clk edge where en=1, i_valid=1 and the block is accumulating.
//   - The producer is never stalled. Pairs presented while the block is outside accumulation are dropped.
//   - o_valid is a one-cycle pulse qualifying o_sum/o_row_idx.
//   - o_done is a one-cycle pulse after the last row of a pass.
//
// Signals:
//   en        global enable (0 freezes everything except the output pulses)
//   i_start   begin a pass (honoured only when idle)
//   i_valid   i_w/i_x valid
//   i_w, i_x  signed fixed-point operands
//   o_sum     saturated row result
//   o_row_idx row index of o_sum
//   o_valid   result pulse
//   o_done    end-of-pass pulse
//   o_busy    block is not idle
//   dbg_state current FSM state encoding
interface mac_row_acc_if #(
    parameter int WIDTH     = 12,
    parameter int CNT_WIDTH = 12
);
    logic                    en;
    logic                    i_start;
    logic                    i_valid;
    logic signed [WIDTH-1:0] i_w;
    logic signed [WIDTH-1:0] i_x;
    logic signed [WIDTH-1:0] o_sum;
    logic [CNT_WIDTH-1:0]    o_row_idx;
    logic                    o_valid;
    logic                    o_done;
    logic                    o_busy;
    logic [1:0]              dbg_state;

    modport master (
        output en, i_start, i_valid, i_w, i_x,
        input  o_sum, o_row_idx, o_valid, o_done, o_busy, dbg_state
    );

    modport slave (
        input  en, i_start, i_valid, i_w, i_x,
        output o_sum, o_row_idx, o_valid, o_done, o_busy, dbg_state
    );
endinterface

// File: rtl/mac_row_acc.sv
// mac_row_acc: per-row signed fixed-point dot-product accumulator.
//
// Operation:
//   - Accumulates LEN products i_w*i_x per row.
//   - Each row result is shifted right by FRAC and saturated to WIDTH bits.
//   - The result is emitted as o_sum/o_row_idx with an o_valid pulse.
//   - After ROWS rows, o_done pulses and the block returns to idle.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  mac_row_acc_if.slave; signal list is in the interface file
module mac_row_acc #(
    parameter int WIDTH     = 12,
    parameter int FRAC      = 8,
    parameter int LEN       = 53,
    parameter int ROWS      = 53,
    parameter int ACC_WIDTH = 32,
    parameter int CNT_WIDTH = 12
) (
    input  logic         clk,
    input  logic         rst,
    mac_row_acc_if.slave bus
);
    localparam int PROD_W = 2 * WIDTH;

    // Saturation bounds expressed at accumulator width so the compare is signed end to end.
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_OUT  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state, state_nx;

    logic signed [ACC_WIDTH-1:0] acc;
    logic [CNT_WIDTH-1:0]        elem;
    logic [CNT_WIDTH-1:0]        row;
    logic signed [WIDTH-1:0]     sum_r;
    logic [CNT_WIDTH-1:0]        row_idx_r;
    logic                        valid_r;
    logic                        done_r;

    logic signed [PROD_W-1:0]    prod;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] acc_shift;
    logic signed [WIDTH-1:0]     sat_val;
    logic                        last_elem;
    logic                        last_row;
    logic                        accept;

    // Both operands are signed, so the multiply is a full signed product.
    assign prod      = bus.i_w * bus.i_x;
    assign prod_ext  = {{(ACC_WIDTH-PROD_W){prod[PROD_W-1]}}, prod};
    // Arithmetic shift: truncation toward minus infinity, no rounding.
    assign acc_shift = acc >>> FRAC;
    assign last_elem = (elem == CNT_WIDTH'(LEN - 1));
    assign last_row  = (row == CNT_WIDTH'(ROWS - 1));
    assign accept    = (state == S_ACC) && bus.i_valid;

    always_comb begin
        sat_val = acc_shift[WIDTH-1:0];
        if (acc_shift > SAT_MAX) begin
            sat_val = SAT_MAX[WIDTH-1:0];
        end else if (acc_shift < SAT_MIN) begin
            sat_val = SAT_MIN[WIDTH-1:0];
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (bus.i_start) state_nx = S_ACC;
            S_ACC:  if (bus.i_valid && last_elem) state_nx = S_OUT;
            S_OUT:  state_nx = last_row ? S_DONE : S_ACC;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else if (bus.en) begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            elem      <= '0;
            row       <= '0;
            sum_r     <= '0;
            row_idx_r <= '0;
            valid_r   <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            // Pulses drop on the next edge regardless of en.
            valid_r <= 1'b0;
            done_r  <= 1'b0;
            if (bus.en) begin
                case (state)
                    S_IDLE: begin
                        if (bus.i_start) begin
                            acc  <= '0;
                            elem <= '0;
                            row  <= '0;
                        end
                    end
                    S_ACC: begin
                        if (accept) begin
                            acc  <= acc + prod_ext;
                            elem <= last_elem ? '0 : elem + 1'b1;
                        end
                    end
                    S_OUT: begin
                        sum_r     <= sat_val;
                        row_idx_r <= row;
                        valid_r   <= 1'b1;
                        acc       <= '0;
                        // The row counter stays on the last row until the next start.
                        if (!last_row) row <= row + 1'b1;
                    end
                    S_DONE: begin
                        done_r <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.o_sum     = sum_r;
    assign bus.o_row_idx = row_idx_r;
    assign bus.o_valid   = valid_r;
    assign bus.o_done    = done_r;
    assign bus.o_busy    = (state != S_IDLE);
    assign bus.dbg_state = state;
endmodule
